// File: rtl/int_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per clock; valid/ready handshake on request and response.
module int_div #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_next;
  logic [N-1:0]  dvd, dvs, prem;
  logic [CW-1:0] cnt;
  logic          neg_q, neg_r;

  logic          a_neg, b_neg, div_zero, special, last;
  logic [N-1:0]  abs_a, abs_b;
  logic [N:0]    shifted, diff;
  logic          borrow;
  logic [N-1:0]  nxt_quo, nxt_rem;

  assign a_neg    = is_signed & a[N-1];
  assign b_neg    = is_signed & b[N-1];
  assign abs_a    = a_neg ? -a : a;
  assign abs_b    = b_neg ? -b : b;
  assign div_zero = (b == '0);
  assign special  = div_zero || (is_signed && (a == MIN_NEG) && (b == '1));

  // prem < dvs always holds, so bit N of the (N+1)-bit difference is exactly the borrow
  assign shifted = {prem, dvd[N-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign borrow  = diff[N];
  assign nxt_rem = borrow ? shifted[N-1:0] : diff[N-1:0];
  assign nxt_quo = {dvd[N-2:0], ~borrow};
  assign last    = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = special ? DONE : CALC;
      end
      CALC: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd   <= '0;
      dvs   <= '0;
      prem  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (special) begin
              quot <= div_zero ? '1 : a;
              rem  <= div_zero ? a : '0;
            end else begin
              dvd   <= abs_a;
              dvs   <= abs_b;
              prem  <= '0;
              cnt   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        CALC: begin
          dvd  <= nxt_quo;
          prem <= nxt_rem;
          cnt  <= cnt + CW'(1);
          if (last) begin
            quot <= neg_q ? -nxt_quo : nxt_quo;
            rem  <= neg_r ? -nxt_rem : nxt_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div.sv
// Directed self-checking bench for int_div (N=32): vector table plus
// backpressure and mid-operation reset sequences.
module tb_int_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quot, rem;

  int checks = 0;
  int errors = 0;

  int_div #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    is_signed = sv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counted in falling edges after the accept edge until out_valid is seen.
  task automatic wait_result(input string name, input int exp_lat,
                             input logic [31:0] q, input logic [31:0] r, input bit ack);
    int lat = 0;
    bit seen = 0;
    bit busy_ready = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        seen = 1;
        break;
      end
      if (in_ready) busy_ready = 1;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_in_ready_busy"}, 32'(busy_ready), 32'd0);
    if (seen) begin
      chk({name, "_quot"}, quot, q);
      chk({name, "_rem"}, rem, r);
      chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
    end
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    bit bad;
    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        33};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        33};
    vecs[3]  = '{32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678, 1};
    vecs[4]  = '{32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678, 1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 33};
    vecs[7]  = '{32'hFFFFFFFF, 32'h10,       1'b0, 32'h0FFFFFFF, 32'hF,        33};
    vecs[8]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 33};
    vecs[9]  = '{32'hFFFFFFFF, 32'h80000000, 1'b0, 32'd1,        32'h7FFFFFFF, 33};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1,        32'd0,        33};
    vecs[11] = '{32'd0,        32'd5,        1'b0, 32'd0,        32'd0,        33};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    is_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quot", quot, 32'd0);
    chk("reset_rem", rem, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_result($sformatf("vec%0d", i), vecs[i].lat, vecs[i].q, vecs[i].r, 1'b1);
    end

    // Backpressure: response held while a new request waits at the input.
    start_op(32'd100, 32'd7, 1'b0);
    wait_result("bp", 33, 32'd14, 32'd2, 1'b0);
    a = 32'd50;
    b = 32'd5;
    is_signed = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_quot", quot, 32'd14);
      chk("bp_hold_rem", rem, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_ack_valid", 32'(out_valid), 32'd0);
    chk("bp_after_ack_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result("bp_next", 33, 32'd10, 32'd0, 1'b1);

    // Reset in the middle of CALC aborts the operation.
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quot", quot, 32'd0);
    chk("abort_rem", rem, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad = 1;
    end
    chk("abort_idle_after_reset", 32'(bad), 32'd0);
    start_op(32'hFFFFFFFF, 32'h10, 1'b0);
    wait_result("post_reset", 33, 32'h0FFFFFFF, 32'hF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
